dst_decode_stage: RTL and testbench

Registered, parametrised destination-operand decode stage of the ASIP pipeline, between instruction fetch/issue and the register file, data RAM and PC logic. It decodes the destination field against the opcode into one-hot register, data-RAM and jump controls. A valid/ready output register and a per-GPR busy scoreboard stall issue on write-after-write hazards against in-flight multicycle ALU results.

---
 rtl/dst_dec_pkg.sv | 37 +++
 rtl/dst_scoreboard.sv | 43 ++++
 rtl/dst_decode_stage.sv | 202 ++++++++++++++++++++
 tb/tb_dst_decode_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_dec_pkg.sv
// Shared constants and helpers for the destination-operand decode stage.
// Opcode values, destination class codes and the opcode classifier used by
// dst_decode_stage.
package dst_dec_pkg;

    localparam int unsigned OPR_MOV = 1;
    localparam int unsigned OPR_JMP = 16;
    localparam int unsigned OPR_JRE = 17;

    localparam logic [2:0] CLS_GPR  = 3'b000;
    localparam logic [2:0] CLS_DMEM = 3'b001;
    localparam logic [2:0] CLS_RMOD = 3'b100;
    localparam logic [2:0] CLS_IND  = 3'b101;

    // Pointer registers are addressed as indices SPR_BASE..SPR_BASE+NSPR-1.
    localparam int unsigned SPR_BASE = 32;

    typedef enum logic [1:0] {
        OP_OTHER,
        OP_MOV,
        OP_ALU,
        OP_JMP
    } op_kind_e;

    function automatic logic is_alu_opr(input int unsigned op);
        return ((op >= 2) && (op <= 6)) || ((op >= 8) && (op <= 12));
    endfunction

    // JMP and JRE share one kind; they differ only in jmp_addr_sel.
    function automatic op_kind_e op_kind(input int unsigned op);
        if (op == OPR_MOV)                    return OP_MOV;
        if (is_alu_opr(op))                   return OP_ALU;
        if (op == OPR_JMP || op == OPR_JRE)   return OP_JMP;
        return OP_OTHER;
    endfunction

endpackage

// File: rtl/dst_scoreboard.sv
// Per-GPR busy scoreboard for in-flight multicycle ALU results.
// Ports:
//   set_mask  - one-hot GPR set on a legal ALU issue
//   clr_en/clr_idx - ALU writeback, clears the matching bit
//   fl_mask   - one-hot clear for a flushed ALU entry
//   q_mask    - one-hot target being issued; q_busy is its busy state with
//               the same-cycle writeback already applied (bypass)
//   busy_vec  - registered busy state
module dst_scoreboard #(
    parameter int NGPR = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NGPR-1:0]           set_mask,
    input  logic                      clr_en,
    input  logic [$clog2(NGPR)-1:0]   clr_idx,
    input  logic [NGPR-1:0]           fl_mask,
    input  logic [NGPR-1:0]           q_mask,
    output logic                      q_busy,
    output logic [NGPR-1:0]           busy_vec
);

    logic [NGPR-1:0] busy_q, busy_d;
    logic [NGPR-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < NGPR; i++) begin
            clr_mask[i] = clr_en && (32'(clr_idx) == i);
        end
        // Set is applied last so a same-cycle set and clear keeps the bit.
        busy_d = (busy_q & ~clr_mask & ~fl_mask) | set_mask;
        q_busy = |(q_mask & busy_q & ~clr_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/dst_decode_stage.sv
// Registered destination-operand decode stage.
// Decodes dst_code against opr_code into one-hot register, data-RAM and jump
// controls, held in a valid/ready output register. A busy scoreboard stalls
// issue on write-after-write hazards against in-flight ALU results.
// Ports:
//   in_valid/in_ready, opr_code, dst_code - issue side
//   out_valid/out_ready, flush            - downstream side
//   wb_valid/wb_idx                       - ALU writeback clears busy
//   gpr_*/spr_*/rmod_*/dat_ram_*/indir_*  - decoded selects (registered)
//   jmp_*                                 - jump controls; jmp_addr is held
//   dst_err                               - illegal destination in held entry
//   busy_vec                              - scoreboard state
module dst_decode_stage
    import dst_dec_pkg::*;
#(
    parameter int DST_W     = 9,
    parameter int OPR_W     = 5,
    parameter int NGPR      = 8,
    parameter int NSPR      = 2,
    parameter int DMEMADDRW = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPR_W-1:0]          opr_code,
    input  logic [DST_W-1:0]          dst_code,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      flush,
    input  logic                      wb_valid,
    input  logic [$clog2(NGPR)-1:0]   wb_idx,
    output logic [NGPR-1:0]           gpr_r_sel,
    output logic [NGPR-1:0]           gpr_t_sel,
    output logic [NSPR-1:0]           spr_r_sel,
    output logic                      rmod_t_sel,
    output logic                      dat_ram_addr_en_b,
    output logic                      dat_ram_rw,
    output logic [DMEMADDRW-1:0]      dat_ram_addr,
    output logic                      indir_addr_sel,
    output logic                      jmp_addr_sel,
    output logic                      jmp_valid,
    output logic [DST_W-1:0]          jmp_addr,
    output logic                      dst_err,
    output logic [NGPR-1:0]           busy_vec
);

    localparam int IDX_W = DST_W - 3;

    typedef struct packed {
        logic [NGPR-1:0]      gpr_r;
        logic [NGPR-1:0]      gpr_t;
        logic [NGPR-1:0]      alu;    // legal ALU target, for flush-clear
        logic [NSPR-1:0]      spr;
        logic                 rmod;
        logic                 en_b;
        logic                 rw;
        logic [DMEMADDRW-1:0] addr;
        logic                 ind;
        logic                 jsel;
        logic                 jv;
        logic                 err;
    } ent_t;

    logic [2:0]       cls;
    logic [IDX_W-1:0] idx;
    int unsigned      opr_u, idx_u;
    op_kind_e         kind;
    logic [NGPR-1:0]  gpr_hit;
    logic [NSPR-1:0]  spr_hit;
    ent_t             dec;

    ent_t             ent_q, ent_d;
    logic             out_valid_q, out_valid_d;
    logic [DST_W-1:0] jmp_addr_q, jmp_addr_d;

    logic             hazard, fire;
    logic [NGPR-1:0]  set_mask, fl_mask;

    assign cls = dst_code[DST_W-1 -: 3];
    assign idx = dst_code[IDX_W-1:0];

    always_comb begin
        opr_u = 32'(opr_code);
        idx_u = 32'(idx);
        kind  = op_kind(opr_u);

        // Range checks fall out of the one-hot match: no hit means illegal.
        gpr_hit = '0;
        for (int unsigned i = 0; i < NGPR; i++) gpr_hit[i] = (idx_u == i);
        spr_hit = '0;
        for (int unsigned i = 0; i < NSPR; i++) spr_hit[i] = (idx_u == SPR_BASE + i);

        dec      = '0;
        dec.en_b = 1'b1;
        dec.rw   = 1'b1;
        case (kind)
            OP_MOV: begin
                case (cls)
                    CLS_GPR: begin
                        if (|gpr_hit) dec.gpr_t = gpr_hit;
                        else          dec.err   = 1'b1;
                    end
                    CLS_DMEM: begin
                        dec.en_b = 1'b0;
                        dec.rw   = 1'b0;
                        dec.addr = DMEMADDRW'(idx);
                    end
                    CLS_RMOD: dec.rmod = 1'b1;
                    CLS_IND: begin
                        if (|spr_hit) begin
                            dec.en_b = 1'b0;
                            dec.rw   = 1'b0;
                            dec.ind  = 1'b1;
                            dec.spr  = spr_hit;
                        end else begin
                            dec.err = 1'b1;
                        end
                    end
                    default: dec.err = 1'b1;
                endcase
            end
            OP_ALU: begin
                if (|gpr_hit) begin
                    dec.gpr_r = gpr_hit;
                    dec.gpr_t = gpr_hit;
                    dec.alu   = gpr_hit;
                end else begin
                    dec.err = 1'b1;
                end
            end
            OP_JMP: begin
                dec.jv   = 1'b1;
                dec.jsel = (opr_u == OPR_JMP);
            end
            default: ;
        endcase
    end

    // gpr_t is non-zero only for a legal GPR write, so it doubles as the
    // hazard query mask.
    dst_scoreboard #(.NGPR(NGPR)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mask (set_mask),
        .clr_en   (wb_valid),
        .clr_idx  (wb_idx),
        .fl_mask  (fl_mask),
        .q_mask   (dec.gpr_t),
        .q_busy   (hazard),
        .busy_vec (busy_vec)
    );

    assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;
    assign set_mask = fire ? dec.alu : '0;
    assign fl_mask  = (flush && out_valid_q) ? ent_q.alu : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        ent_d       = ent_q;
        jmp_addr_d  = jmp_addr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            ent_d       = dec;
            if (dec.jv) jmp_addr_d = dst_code;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ent_q       <= '0;
            ent_q.en_b  <= 1'b1;
            ent_q.rw    <= 1'b1;
            jmp_addr_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ent_q       <= ent_d;
            jmp_addr_q  <= jmp_addr_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign gpr_r_sel         = ent_q.gpr_r;
    assign gpr_t_sel         = ent_q.gpr_t;
    assign spr_r_sel         = ent_q.spr;
    assign rmod_t_sel        = ent_q.rmod;
    assign dat_ram_addr_en_b = ent_q.en_b;
    assign dat_ram_rw        = ent_q.rw;
    assign dat_ram_addr      = ent_q.addr;
    assign indir_addr_sel    = ent_q.ind;
    assign jmp_addr_sel      = ent_q.jsel;
    assign jmp_valid         = ent_q.jv;
    assign dst_err           = ent_q.err;
    assign jmp_addr          = jmp_addr_q;

endmodule

// File: tb/tb_dst_decode_stage.sv
module tb_dst_decode_stage;
    localparam int DST_W = 9, OPR_W = 5, NGPR = 8, NSPR = 2, DMEMADDRW = 10;
    localparam int GW = $clog2(NGPR);

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic in_valid = 0, out_ready = 0, flush = 0, wb_valid = 0;
    logic [OPR_W-1:0] opr_code = '0;
    logic [DST_W-1:0] dst_code = '0;
    logic [GW-1:0]    wb_idx = '0;
    logic in_ready, out_valid, rmod_t_sel, dat_ram_addr_en_b, dat_ram_rw;
    logic indir_addr_sel, jmp_addr_sel, jmp_valid, dst_err;
    logic [NGPR-1:0] gpr_r_sel, gpr_t_sel, busy_vec;
    logic [NSPR-1:0] spr_r_sel;
    logic [DMEMADDRW-1:0] dat_ram_addr;
    logic [DST_W-1:0] jmp_addr;

    dst_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opr_code(opr_code), .dst_code(dst_code), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .wb_valid(wb_valid), .wb_idx(wb_idx),
        .gpr_r_sel(gpr_r_sel), .gpr_t_sel(gpr_t_sel), .spr_r_sel(spr_r_sel),
        .rmod_t_sel(rmod_t_sel), .dat_ram_addr_en_b(dat_ram_addr_en_b),
        .dat_ram_rw(dat_ram_rw), .dat_ram_addr(dat_ram_addr),
        .indir_addr_sel(indir_addr_sel), .jmp_addr_sel(jmp_addr_sel),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .dst_err(dst_err),
        .busy_vec(busy_vec)
    );

    typedef struct {
        logic [NGPR-1:0] gr, gt;
        logic [NSPR-1:0] spr;
        logic rmod, en_b, rw, ind, jsel, jv, err;
        logic [DMEMADDRW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0;

    // Reference state: busy registers, held entry, jump address.
    bit busy_m[NGPR];
    bit held_v;
    int held_alu;
    logic [DST_W-1:0] jmp_m;
    bit push_now, mon_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference decode, from the opcode/class rules directly.
    function automatic void ref_decode(input int op, input int cls, input int idx,
                                       output exp_t e, output int tgt, output bit alu);
        e = '{gr: '0, gt: '0, spr: '0, rmod: 0, en_b: 1, rw: 1, ind: 0,
              jsel: 0, jv: 0, err: 0, addr: '0};
        tgt = -1;
        alu = 0;
        if (op == 1) begin
            if (cls == 0) begin
                if (idx < NGPR) begin e.gt[idx] = 1; tgt = idx; end
                else e.err = 1;
            end else if (cls == 1) begin
                e.en_b = 0; e.rw = 0; e.addr = DMEMADDRW'(idx);
            end else if (cls == 4) begin
                e.rmod = 1;
            end else if (cls == 5) begin
                if (idx >= 32 && idx < 32 + NSPR) begin
                    e.en_b = 0; e.rw = 0; e.ind = 1; e.spr[idx - 32] = 1;
                end else e.err = 1;
            end else e.err = 1;
        end else if ((op >= 2 && op <= 6) || (op >= 8 && op <= 12)) begin
            if (idx < NGPR) begin
                e.gr[idx] = 1; e.gt[idx] = 1; tgt = idx; alu = 1;
            end else e.err = 1;
        end else if (op == 16 || op == 17) begin
            e.jv = 1; e.jsel = (op == 16);
        end
    endfunction

    // One clock of stimulus; updates the reference and queues expectations.
    task automatic step(input bit iv, input int op, input int dst, input bit ordy,
                        input bit fl, input bit wv, input int wi);
        exp_t e; int tgt; bit alu, hz, rdy, fire;
        logic [DST_W-1:0] d;
        logic [NGPR-1:0] bm;
        @(negedge clk);
        for (int i = 0; i < NGPR; i++) bm[i] = busy_m[i];
        chk("busy_vec", busy_vec, bm);
        chk("jmp_addr", jmp_addr, jmp_m);
        in_valid = iv; opr_code = OPR_W'(op); dst_code = DST_W'(dst);
        out_ready = ordy; flush = fl; wb_valid = wv; wb_idx = GW'(wi);
        d = DST_W'(dst);
        ref_decode(op, int'(d[DST_W-1:DST_W-3]), int'(d[DST_W-4:0]), e, tgt, alu);
        hz = 0;
        if (tgt >= 0) hz = busy_m[tgt] && !(wv && wi == tgt);
        rdy = !fl && !hz && (!held_v || ordy);
        #1;
        chk("in_ready", in_ready, rdy);
        fire = iv && rdy;
        if (wv) busy_m[wi] = 0;
        if (fl && held_v && held_alu >= 0) busy_m[held_alu] = 0;
        if (fire && alu) busy_m[tgt] = 1;
        if (held_v && (fl || ordy)) held_v = 0;
        push_now = fire;
        if (fire) begin
            held_v = 1;
            held_alu = alu ? tgt : -1;
            exp_q.push_back(e);
            if (e.jv) jmp_m = d;
        end
    endtask

    // Monitor: compares the presented entry against the scoreboard head.
    initial begin
        exp_t e; int pend;
        forever begin
            @(negedge clk); #2;
            if (mon_en) begin
                pend = exp_q.size() - (push_now ? 1 : 0);
                chk("out_valid", out_valid, pend > 0);
                if (out_valid && pend > 0) begin
                    e = exp_q[0];
                    if (flush) void'(exp_q.pop_front());
                    else begin
                        chk("gpr_r_sel", gpr_r_sel, e.gr);
                        chk("gpr_t_sel", gpr_t_sel, e.gt);
                        chk("spr_r_sel", spr_r_sel, e.spr);
                        chk("rmod_t_sel", rmod_t_sel, e.rmod);
                        chk("en_b", dat_ram_addr_en_b, e.en_b);
                        chk("rw", dat_ram_rw, e.rw);
                        chk("addr", dat_ram_addr, e.addr);
                        chk("indir", indir_addr_sel, e.ind);
                        chk("jmp_sel", jmp_addr_sel, e.jsel);
                        chk("jmp_valid", jmp_valid, e.jv);
                        chk("dst_err", dst_err, e.err);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NGPR; i++) busy_m[i] = 0;
        held_v = 0; held_alu = -1; jmp_m = '0; push_now = 0;
        exp_q.delete();
    endtask

    function automatic int rnd_op();
        int t = int'($urandom_range(0, 9));
        int p;
        if (t < 3) return 1;
        if (t < 6) begin p = int'($urandom_range(0, 9)); return (p < 5) ? 2 + p : 3 + p; end
        if (t == 6) return 16;
        if (t == 7) return 17;
        if (t == 8) return 0;
        return int'($urandom_range(0, 31));
    endfunction

    function automatic int rnd_dst();
        int t = int'($urandom_range(0, 9));
        int cls, idx;
        cls = (t < 4) ? 0 : (t < 6) ? 5 : int'($urandom_range(0, 7));
        t = int'($urandom_range(0, 9));
        idx = (t < 5) ? int'($urandom_range(0, 9)) : (t < 7) ? int'($urandom_range(31, 34))
                                                    : int'($urandom_range(0, 63));
        return cls * 64 + idx;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        mon_en = 0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_jmp_addr", jmp_addr, 0);
        chk("rst_en_b", dat_ram_addr_en_b, 1);
        chk("rst_rw", dat_ram_rw, 1);
        @(negedge clk); rst_n = 1; mon_en = 1;

        // MOV r3
        step(1, 1, 9'b000_000011, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp1_valid", out_valid, 1);
        chk("tp1_gt", gpr_t_sel, 8'h08);
        chk("tp1_gr", gpr_r_sel, 0);
        chk("tp1_err", dst_err, 0);
        // MOV indirect via pointer 33, then illegal pointer 40
        step(1, 1, 9'b101_100001, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp2_spr", spr_r_sel, 2'b10);
        chk("tp2_ind", indir_addr_sel, 1);
        chk("tp2_en_b", dat_ram_addr_en_b, 0);
        chk("tp2_rw", dat_ram_rw, 0);
        step(1, 1, 9'b101_101000, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp2_err", dst_err, 1);
        chk("tp2_spr_def", spr_r_sel, 0);
        chk("tp2_en_b_def", dat_ram_addr_en_b, 1);
        // WAW on r5, released by same-cycle writeback
        step(1, 3, 5, 1, 0, 0, 0);
        step(1, 3, 5, 1, 0, 0, 0);
        chk("tp3_stall", in_ready, 0);
        chk("tp3_busy", busy_vec, 8'h20);
        step(1, 3, 5, 1, 0, 1, 5);
        chk("tp3_bypass", in_ready, 1);
        @(posedge clk); #1;
        chk("tp3_busy_kept", busy_vec, 8'h20);
        // JMP then MOV, then JRE
        step(1, 16, 'h1A5, 1, 0, 1, 5);
        step(1, 1, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp4_jmp_hold", jmp_addr, 9'h1A5);
        chk("tp4_jv_mov", jmp_valid, 0);
        step(1, 17, 'h010, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp4_jre_sel", jmp_addr_sel, 0);
        chk("tp4_jre_addr", jmp_addr, 9'h010);
        // Stall three cycles on held ALU r2, then flush it
        step(1, 2, 2, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            chk("tp5_inrdy", in_ready, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk("tp5_flush_valid", out_valid, 0);
        chk("tp5_flush_busy2", busy_vec[2], 0);
        // Reset in the middle of a stall with busy = 0x81
        step(1, 2, 0, 1, 0, 0, 0);
        step(1, 2, 7, 1, 0, 0, 0);
        step(1, 16, 'h0F0, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        chk("tp6_busy", busy_vec, 8'h81);
        #2; mon_en = 0; rst_n = 0; #1;
        chk("tp6_busy_clr", busy_vec, 0);
        chk("tp6_valid", out_valid, 0);
        chk("tp6_jmp", jmp_addr, 0);
        chk("tp6_inrdy", in_ready, 0);
        model_reset();
        in_valid = 0; out_ready = 0; flush = 0; wb_valid = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk); mon_en = 1;

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 80, rnd_op(), rnd_dst(),
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 30, int'($urandom_range(0, NGPR - 1)));
        end
        for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0, 0, 0);
        #5;
        chk("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
